muldiv_unit: RTL and testbench

Multicycle integer multiply/divide unit for the MIPS core, beside the ALU in the execute stage. It takes register-file operands rs/rt and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into private HI/LO registers. HI/LO feed the MFHI/MFLO result mux. `busy` stalls the pipeline while an operation iterates.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 27 ++
 rtl/md_abs32.sv | 14 +
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit, also imported by the core decoder
// and hazard unit so the op field means the same thing everywhere.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  localparam int MD_ITERS = 32;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between the core and the multiply/divide unit:
// launch/operands and HI/LO writes in, busy and HI/LO out.
interface muldiv_if;
  import muldiv_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_abs32.sv
// 32-bit conditional two's-complement negate; o_neg reports whether the value
// was negated (i.e. the effective sign that was stripped or applied).
module md_abs32 (
  input  logic [31:0] i_val,
  input  logic        i_en,
  input  logic        i_sign,
  output logic [31:0] o_val,
  output logic        o_neg
);

  assign o_neg = i_en & i_sign;
  assign o_val = o_neg ? (~i_val + 32'd1) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle radix-2 multiply/divide unit with private HI/LO registers.
// Magnitudes are iterated unsigned for 32 cycles, then signs are fixed in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  md_state_e r_state;
  md_state_e w_state_next;
  logic [4:0] r_cnt;

  logic w_idle;
  logic w_load;
  logic w_step;
  logic w_fix;
  logic w_busy;

  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_a_raw;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_is_div;
  logic        r_div0;
  logic        r_sign_a;
  logic        r_sign_b;

  // Lanes 0/1 strip operand signs at launch; lanes 2/3 restore quotient/remainder signs at FIX.
  logic [3:0][31:0] w_lane_in;
  logic [3:0]       w_lane_en;
  logic [3:0]       w_lane_sign;
  logic [3:0][31:0] w_lane_out;
  logic [3:0]       w_lane_neg;

  always_comb begin
    w_lane_in   = '0;
    w_lane_en   = '0;
    w_lane_sign = '0;
    w_lane_in[0]   = md.a;
    w_lane_en[0]   = op_is_signed(md.op);
    w_lane_sign[0] = md.a[31];
    w_lane_in[1]   = md.b;
    w_lane_en[1]   = op_is_signed(md.op);
    w_lane_sign[1] = md.b[31];
    w_lane_in[2]   = r_acc[31:0];
    w_lane_en[2]   = 1'b1;
    w_lane_sign[2] = r_sign_a ^ r_sign_b;
    w_lane_in[3]   = r_acc[63:32];
    w_lane_en[3]   = 1'b1;
    w_lane_sign[3] = r_sign_a;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      md_abs32 u_abs (
        .i_val  (w_lane_in[gi]),
        .i_en   (w_lane_en[gi]),
        .i_sign (w_lane_sign[gi]),
        .o_val  (w_lane_out[gi]),
        .o_neg  (w_lane_neg[gi])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (md.start) w_state_next = RUN;
      RUN:     if (r_cnt == 5'(MD_ITERS - 1)) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_idle = (r_state == IDLE);
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      IDLE: begin
        w_load = md.start;
        w_busy = 1'b0;
      end
      RUN:     w_step = 1'b1;
      FIX:     w_fix  = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide step: restoring; remainder in the upper half, dividend/quotient shifting in the lower half.
  logic [32:0] w_rem_sh;
  logic [33:0] w_diff;
  logic        w_borrow;
  logic [63:0] w_div_next;
  assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opnd};
  assign w_borrow   = w_diff[33];
  assign w_div_next = {(w_borrow ? w_rem_sh[31:0] : w_diff[31:0]), r_acc[30:0], ~w_borrow};

  logic [63:0] w_prod;
  assign w_prod = w_lane_neg[2] ? (~r_acc + 64'd1) : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_load) begin
        r_cnt    <= '0;
        r_is_div <= op_is_div(md.op);
        r_div0   <= op_is_div(md.op) && (md.b == 32'd0);
        r_a_raw  <= md.a;
        r_sign_a <= w_lane_neg[0];
        r_sign_b <= w_lane_neg[1];
        if (op_is_div(md.op)) begin
          r_acc  <= {32'd0, w_lane_out[0]};
          r_opnd <= w_lane_out[1];
        end else begin
          r_acc  <= {32'd0, w_lane_out[1]};
          r_opnd <= w_lane_out[0];
        end
      end
      if (w_step) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= r_is_div ? w_div_next : w_mul_next;
      end
      if (w_fix) begin
        if (r_div0) begin
          r_hi <= r_a_raw;
          r_lo <= 32'hFFFF_FFFF;
        end else if (r_is_div) begin
          r_hi <= w_lane_out[3];
          r_lo <= w_lane_out[2];
        end else begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
      end
      // MTHI/MTLO only land while idle; a start in the same cycle is overwritten at FIX.
      if (w_idle && md.hi_we) r_hi <= md.wd;
      if (w_idle && md.lo_we) r_lo <= md.wd;
    end
  end

  assign md.busy = w_busy;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops checked
// against a plain-arithmetic model of MIPS MULT/MULTU/DIV/DIVU semantics.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_if md ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    if (op[1] && b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      case (op)
        2'b00: begin
          up = {32'd0, a} * {32'd0, b};
          eh = up[63:32];
          el = up[31:0];
        end
        2'b01: begin
          sp = sa * sb;
          eh = sp[63:32];
          el = sp[31:0];
        end
        2'b10: begin
          el = a / b;
          eh = a % b;
        end
        default: begin
          sq = sa / sb;
          sr = sa % sb;
          el = sq[31:0];
          eh = sr[31:0];
        end
      endcase
    end
  endfunction

  // Launch one op, optionally spraying start/hi_we/lo_we while busy, and check latency and result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit junk);
    logic [31:0] eh, el;
    int n;
    model(op, a, b, eh, el);
    @(negedge clk);
    md.start = 1'b1;
    md.op    = md_op_e'(op);
    md.a     = a;
    md.b     = b;
    @(posedge clk); #1;
    md.start = 1'b0;
    check("busy_after_start", 32'(md.busy), 32'd1);
    n = 0;
    while (md.busy && n < 40) begin
      if (junk) begin
        md.start = 1'b1;
        md.op    = md_op_e'(2'($urandom_range(0, 3)));
        md.a     = $urandom;
        md.b     = $urandom;
        md.hi_we = 1'b1;
        md.lo_we = 1'b1;
        md.wd    = $urandom;
      end
      n++;
      @(posedge clk); #1;
    end
    md.start = 1'b0;
    md.hi_we = 1'b0;
    md.lo_we = 1'b0;
    check("busy_cycles", 32'(n), 32'd33);
    check("hi", md.hi, eh);
    check("lo", md.lo, el);
    exp_hi = eh;
    exp_lo = el;
    $display("op=%0d a=%h b=%h hi=%h lo=%h busy_cycles=%0d", op, a, b, md.hi, md.lo, n);
  endtask

  initial begin
    logic [31:0] ra, rb, wv;
    logic [1:0]  rop;
    int n;
    checks   = 0;
    failures = 0;
    exp_hi   = '0;
    exp_lo   = '0;
    md.start = 1'b0;
    md.op    = MD_MULTU;
    md.a     = '0;
    md.b     = '0;
    md.hi_we = 1'b0;
    md.lo_we = 1'b0;
    md.wd    = '0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(md.busy), 32'd0);
    check("reset_hi", md.hi, 32'd0);
    check("reset_lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b10, 32'd7, 32'd2, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0);
    run_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);

    // MTHI alone, then MTLO and MTHI together
    @(negedge clk);
    md.hi_we = 1'b1;
    md.wd    = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    md.hi_we = 1'b0;
    check("mthi_hi", md.hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", md.lo, exp_lo);
    $display("mthi wd=deadbeef hi=%h lo=%h", md.hi, md.lo);
    @(negedge clk);
    md.hi_we = 1'b1;
    md.lo_we = 1'b1;
    md.wd    = 32'h0BAD_F00D;
    @(posedge clk); #1;
    md.hi_we = 1'b0;
    md.lo_we = 1'b0;
    check("mthilo_hi", md.hi, 32'h0BAD_F00D);
    check("mthilo_lo", md.lo, 32'h0BAD_F00D);
    $display("mthi+mtlo wd=0badf00d hi=%h lo=%h", md.hi, md.lo);

    // Writes and starts during busy are ignored
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op(2'b11, 32'hF000_0001, 32'd12345, 1'b1);

    // Start and MTHI in the same cycle: write lands at once, result replaces it later
    @(negedge clk);
    md.start = 1'b1;
    md.op    = MD_MULTU;
    md.a     = 32'd6;
    md.b     = 32'd9;
    md.hi_we = 1'b1;
    md.wd    = 32'hCAFE_0001;
    @(posedge clk); #1;
    md.start = 1'b0;
    md.hi_we = 1'b0;
    check("start_mthi_hi", md.hi, 32'hCAFE_0001);
    n = 0;
    while (md.busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("start_mthi_cycles", 32'(n), 32'd33);
    check("start_mthi_res_hi", md.hi, 32'd0);
    check("start_mthi_res_lo", md.lo, 32'd54);
    $display("multu+mthi a=6 b=9 hi=%h lo=%h busy_cycles=%0d", md.hi, md.lo, n);

    // Reset during RUN cycle 10 of a MULT
    @(negedge clk);
    md.start = 1'b1;
    md.op    = MD_MULT;
    md.a     = 32'hFFFF_FF00;
    md.b     = 32'h0000_0333;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrun_busy", 32'(md.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_reset_busy", 32'(md.busy), 32'd0);
    check("midrun_reset_hi", md.hi, 32'd0);
    check("midrun_reset_lo", md.lo, 32'd0);
    $display("reset mid-run busy=%0d hi=%h lo=%h", md.busy, md.hi, md.lo);
    run_op(2'b10, 32'd100, 32'd7, 1'b0);

    // Random ops, back-to-back
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        wv = 32'h8000_0000;
        ra = wv;
      end
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
